// File: rtl/aes_pkg.sv
// Shared AES datapath types: state/byte typedefs and the SubBytes FSM encoding.
package aes_pkg;

    localparam int unsigned NBYTES = 16;

    typedef logic [7:0]          byte_t;
    typedef logic [8*NBYTES-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/subbytes_serial_if.sv
// Valid/ready state handshake into and out of the SubBytes stage.
interface subbytes_serial_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t state_in;
    logic   out_valid;
    logic   out_ready;
    state_t state_out;

    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 forward S-box; also shared with key expansion.
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t x,
    output byte_t y
);

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[x];

endmodule

// File: rtl/subbytes_serial.sv
// Byte-serial AES SubBytes: BPC shared S-boxes walk the 16 state bytes in groups.
module subbytes_serial
    import aes_pkg::*;
#(
    parameter int unsigned BPC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    subbytes_serial_if.slave bus,
    output logic        busy
);

    localparam int unsigned GROUPS = NBYTES / BPC;
    localparam int unsigned CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned GRP_W  = 8 * BPC;
    localparam int unsigned OFF_W  = $clog2(8 * NBYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

    fsm_state_e       state;
    fsm_state_e       state_nx;
    logic [CNT_W-1:0] cnt;
    state_t           state_reg;
    logic [OFF_W-1:0] grp_off;
    logic [GRP_W-1:0] grp_in;
    logic [GRP_W-1:0] grp_sub;

    // Current byte group, selected by the group counter.
    assign grp_off = OFF_W'(int'(cnt) * GRP_W);
    assign grp_in  = state_reg[grp_off +: GRP_W];

    for (genvar g = 0; g < int'(BPC); g++) begin : g_sbox
        aes_sbox u_sbox (
            .x (grp_in[8*g +: 8]),
            .y (grp_sub[8*g +: 8])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid && bus.in_ready) state_nx = BUSY;
            BUSY:    if (cnt == CNT_LAST)              state_nx = DONE;
            DONE:    if (bus.out_ready)                state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status flags are registered copies of the upcoming FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            bus.in_ready  <= (state_nx == IDLE);
            bus.out_valid <= (state_nx == DONE);
            busy          <= (state_nx == BUSY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            state_reg <= '0;
        end else if (state == IDLE && state_nx == BUSY) begin
            cnt       <= '0;
            state_reg <= bus.state_in;
        end else if (state == BUSY) begin
            cnt                          <= cnt + CNT_W'(1);
            state_reg[grp_off +: GRP_W]  <= grp_sub;
        end
    end

    assign bus.state_out = state_reg;

endmodule
